// File: rtl/agc_pkg.sv
// Shared definitions for the multi-channel EMA magnitude detector.
package agc_pkg;

    typedef enum logic {
        MAG_SUM    = 1'b0,
        MAG_MAXMIN = 1'b1
    } mag_mode_e;

    localparam int PIPE_LATENCY = 4;

endpackage

// File: rtl/mag_estimator.sv
// Combinational magnitude estimate of a signed I/Q pair: |I|+|Q| or max+min/2.
module mag_estimator
    import agc_pkg::*;
#(
    parameter int W = 27
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    input  mag_mode_e           i_mode,
    output logic        [W:0]   o_mag
);

    logic [W-1:0] w_abs_a;
    logic [W-1:0] w_abs_b;
    logic [W-1:0] w_max;
    logic [W-1:0] w_min;

    // Negating the most negative value yields 2^(W-1), which is exact as unsigned W bits.
    always_comb begin
        w_abs_a = i_a[W-1] ? -i_a : i_a;
        w_abs_b = i_b[W-1] ? -i_b : i_b;
        w_max   = (w_abs_a >= w_abs_b) ? w_abs_a : w_abs_b;
        w_min   = (w_abs_a >= w_abs_b) ? w_abs_b : w_abs_a;
        if (i_mode == MAG_MAXMIN) begin
            o_mag = {1'b0, w_max} + {1'b0, w_min >> 1};
        end else begin
            o_mag = {1'b0, w_abs_a} + {1'b0, w_abs_b};
        end
    end

endmodule

// File: rtl/multi_chan_ema_detector.sv
// Time-multiplexed I/Q magnitude detector with a per-channel exponential moving average.
// Pipeline: S1 capture, S2 gain multiply, S3 magnitude, S4 EMA update with per-channel state.
module multi_chan_ema_detector
    import agc_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int W_IN   = 16,
    parameter int W_GAIN = 10,
    parameter int BWIDTH = 18,
    parameter int W_OUT  = 48,
    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [W_IN-1:0]   s_chans_dataI,
    input  logic signed [W_IN-1:0]   s_chans_dataQ,
    input  logic        [CW-1:0]     s_chans_chan,
    input  logic                     s_chans_valid,
    input  logic        [W_GAIN-1:0] gain,
    input  logic                     mag_mode,
    input  logic        [BWIDTH-1:0] Filter_Coefficient,
    input  logic                     clear,
    output logic                     Valid_Out,
    output logic        [CW-1:0]     Chan_Out,
    output logic        [W_OUT-1:0]  Output
);

    localparam int          W_P   = W_IN + W_GAIN + 1;
    localparam int          W_X   = W_P + 1;
    localparam int          W_E   = W_OUT + BWIDTH + 2;
    localparam logic [CW:0] NCH_L = (CW+1)'(N_CH);

    if (W_OUT < W_IN + W_GAIN + 2) begin : g_bad_width
        $error("W_OUT must be at least W_IN+W_GAIN+2");
    end

    logic                     r1_valid, r2_valid, r3_valid;
    logic        [CW-1:0]     r1_chan, r2_chan, r3_chan;
    logic signed [W_IN-1:0]   r1_i, r1_q;
    logic        [W_GAIN-1:0] r1_gain;
    mag_mode_e                r1_mode, r2_mode;
    logic        [BWIDTH-1:0] r1_k, r2_k, r3_k;
    logic signed [W_P-1:0]    r2_pi, r2_pq;
    logic        [W_X-1:0]    r3_x;

    logic                     w_chan_ok;
    logic signed [W_P-1:0]    w_i_ext, w_q_ext, w_g_ext;
    logic        [W_X-1:0]    w_x;

    assign w_chan_ok = ({1'b0, s_chans_chan} < NCH_L);
    assign w_i_ext   = W_P'(r1_i);
    assign w_q_ext   = W_P'(r1_q);
    assign w_g_ext   = W_P'({1'b0, r1_gain});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r3_valid <= 1'b0;
        end else begin
            r1_valid <= s_chans_valid && w_chan_ok;
            r2_valid <= r1_valid;
            r3_valid <= r2_valid;
        end
    end

    // Controls travel with the sample so mid-stream changes only affect later samples.
    always_ff @(posedge clk) begin
        r1_chan <= s_chans_chan;
        r1_i    <= s_chans_dataI;
        r1_q    <= s_chans_dataQ;
        r1_gain <= gain;
        r1_mode <= mag_mode_e'(mag_mode);
        r1_k    <= Filter_Coefficient;

        r2_chan <= r1_chan;
        r2_pi   <= w_i_ext * w_g_ext;
        r2_pq   <= w_q_ext * w_g_ext;
        r2_mode <= r1_mode;
        r2_k    <= r1_k;

        r3_chan <= r2_chan;
        r3_x    <= w_x;
        r3_k    <= r2_k;
    end

    mag_estimator #(
        .W      (W_P)
    ) u_mag (
        .i_a    (r2_pi),
        .i_b    (r2_pq),
        .i_mode (r2_mode),
        .o_mag  (w_x)
    );

    logic        [W_OUT-1:0] w_y [N_CH];
    logic        [N_CH-1:0]  w_p;
    logic        [W_OUT-1:0] w_y_cur;
    logic        [W_OUT-1:0] w_x_ext;
    logic                    w_primed;
    logic signed [W_OUT:0]   w_diff;
    logic signed [W_E-1:0]   w_diff_ext, w_k_ext, w_prod;
    logic        [W_OUT-1:0] w_ema;
    logic        [W_OUT-1:0] w_result;

    // State is read combinationally in S4, so a back-to-back update sees the fresh value.
    always_comb begin
        w_y_cur    = w_y[r3_chan];
        w_x_ext    = W_OUT'(r3_x);
        w_primed   = w_p[r3_chan] && !clear;
        w_diff     = $signed({1'b0, w_x_ext}) - $signed({1'b0, w_y_cur});
        w_diff_ext = W_E'(w_diff);
        w_k_ext    = W_E'({1'b0, r3_k});
        w_prod     = w_k_ext * w_diff_ext;
        w_ema      = w_y_cur + W_OUT'(w_prod >>> BWIDTH);
        w_result   = w_primed ? w_ema : w_x_ext;
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        logic             w_wr;
        logic [W_OUT-1:0] r_y;
        logic             r_p;

        assign w_wr = r3_valid && (r3_chan == CW'(gi));

        // An update coinciding with clear still leaves its own channel primed.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_y <= '0;
                r_p <= 1'b0;
            end else if (w_wr) begin
                r_y <= w_result;
                r_p <= 1'b1;
            end else if (clear) begin
                r_p <= 1'b0;
            end
        end

        assign w_y[gi] = r_y;
        assign w_p[gi] = r_p;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Valid_Out <= 1'b0;
            Chan_Out  <= '0;
            Output    <= '0;
        end else begin
            Valid_Out <= r3_valid;
            if (r3_valid) begin
                Chan_Out <= r3_chan;
                Output   <= w_result;
            end
        end
    end

endmodule
